wormhole_switch_allocator: RTL and testbench

Per-output wormhole switch allocator for the 5-port NoC router. Each output port arbitrates among the head flits that request it using round-robin priority. It locks the winning input to that output until the packet's tail flit has transferred. It drives the crossbar select and per-input pop grants, and it is the sequencing layer above the existing round-robin arbiter.

---
 rtl/wormhole_switch_allocator_pkg.sv | 28 ++
 rtl/wormhole_switch_allocator_if.sv | 25 ++
 rtl/wormhole_switch_allocator_rr_port_arbiter.sv | 30 +++
 rtl/wormhole_switch_allocator.sv | 105 ++++++++++
 tb/tb_wormhole_switch_allocator.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/wormhole_switch_allocator_pkg.sv
// Shared router definitions: port count, port indices, crossbar idle code and the
// per-output allocator FSM encoding.
package wormhole_switch_allocator_pkg;

    localparam int unsigned NUM_PORTS = 5;
    localparam int unsigned SEL_W     = 3;

    typedef logic [SEL_W-1:0] port_idx_t;

    localparam port_idx_t PORT_N     = 3'd0;
    localparam port_idx_t PORT_E     = 3'd1;
    localparam port_idx_t PORT_S     = 3'd2;
    localparam port_idx_t PORT_W     = 3'd3;
    localparam port_idx_t PORT_LOCAL = 3'd4;

    localparam port_idx_t XBAR_IDLE = 3'b111;

    typedef enum logic {
        StIdle   = 1'b0,
        StLocked = 1'b1
    } alloc_state_e;

    // Port index plus one, wrapping after the local port.
    function automatic port_idx_t next_port(input port_idx_t p);
        return (p == PORT_LOCAL) ? PORT_N : p + 3'd1;
    endfunction

endpackage

// File: rtl/wormhole_switch_allocator_if.sv
// Allocator handshake bundle between the input buffers / downstream credits and the
// switch allocator.
interface wormhole_switch_allocator_if;
    import wormhole_switch_allocator_pkg::*;

    logic [NUM_PORTS-1:0]       in_valid;
    logic [NUM_PORTS-1:0]       in_head;
    logic [NUM_PORTS-1:0]       in_tail;
    logic [NUM_PORTS*SEL_W-1:0] in_dest;
    logic [NUM_PORTS-1:0]       out_ready;
    logic [NUM_PORTS-1:0]       in_grant;
    logic [NUM_PORTS-1:0]       out_valid;
    logic [NUM_PORTS*SEL_W-1:0] xbar_sel;

    modport master (
        output in_valid, in_head, in_tail, in_dest, out_ready,
        input  in_grant, out_valid, xbar_sel
    );

    modport slave (
        input  in_valid, in_head, in_tail, in_dest, out_ready,
        output in_grant, out_valid, xbar_sel
    );

endinterface

// File: rtl/wormhole_switch_allocator_rr_port_arbiter.sv
// Combinational round-robin arbiter for one output: first request at or above ptr,
// wrapping modulo the port count.
module rr_port_arbiter
    import wormhole_switch_allocator_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  port_idx_t            ptr,
    output logic [NUM_PORTS-1:0] gnt,
    output port_idx_t            idx
);

    port_idx_t cand;
    logic      found;

    always_comb begin
        gnt   = '0;
        idx   = XBAR_IDLE;
        found = 1'b0;
        cand  = ptr;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (!found && req[cand]) begin
                found     = 1'b1;
                idx       = cand;
                gnt[cand] = 1'b1;
            end
            cand = next_port(cand);
        end
    end

endmodule

// File: rtl/wormhole_switch_allocator.sv
// Per-output wormhole switch allocator: round-robin head arbitration, then the winner
// holds the output until its tail flit transfers.
module wormhole_switch_allocator
    import wormhole_switch_allocator_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    wormhole_switch_allocator_if.slave  bus
);

    alloc_state_e         state_q [NUM_PORTS];
    alloc_state_e         state_d [NUM_PORTS];
    port_idx_t            owner_q [NUM_PORTS];
    port_idx_t            owner_d [NUM_PORTS];
    port_idx_t            ptr_q   [NUM_PORTS];
    port_idx_t            ptr_d   [NUM_PORTS];

    logic [NUM_PORTS-1:0] owned;
    logic [NUM_PORTS-1:0] req     [NUM_PORTS];
    logic [NUM_PORTS-1:0] arb_gnt [NUM_PORTS];
    port_idx_t            arb_idx [NUM_PORTS];
    logic [NUM_PORTS-1:0] xfer;

    // An input already holding a locked output may not compete for another one.
    always_comb begin
        owned = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            if (state_q[o] == StLocked) owned[owner_q[o]] = 1'b1;
        end
    end

    always_comb begin
        for (int o = 0; o < NUM_PORTS; o++) begin
            req[o] = '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                req[o][i] = bus.in_valid[i] && bus.in_head[i] && !owned[i] &&
                            (bus.in_dest[SEL_W*i +: SEL_W] == port_idx_t'(o));
            end
        end
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : gen_arb
        rr_port_arbiter u_arb (
            .req (req[g]),
            .ptr (ptr_q[g]),
            .gnt (arb_gnt[g]),
            .idx (arb_idx[g])
        );
    end

    always_comb begin
        bus.in_grant  = '0;
        bus.out_valid = '0;
        bus.xbar_sel  = {NUM_PORTS{XBAR_IDLE}};
        xfer          = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            if (state_q[o] == StLocked) begin
                bus.xbar_sel[SEL_W*o +: SEL_W] = owner_q[o];
                xfer[o] = bus.in_valid[owner_q[o]] && bus.out_ready[o];
            end
            if (xfer[o]) begin
                bus.out_valid[o]          = 1'b1;
                bus.in_grant[owner_q[o]]  = 1'b1;
            end
        end
    end

    always_comb begin
        for (int o = 0; o < NUM_PORTS; o++) begin
            state_d[o] = state_q[o];
            owner_d[o] = owner_q[o];
            ptr_d[o]   = ptr_q[o];
            unique case (state_q[o])
                StIdle: begin
                    if (|arb_gnt[o]) begin
                        state_d[o] = StLocked;
                        owner_d[o] = arb_idx[o];
                        ptr_d[o]   = next_port(arb_idx[o]);
                    end
                end
                StLocked: begin
                    if (xfer[o] && bus.in_tail[owner_q[o]]) state_d[o] = StIdle;
                end
                default: state_d[o] = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                state_q[o] <= StIdle;
                owner_q[o] <= '0;
                ptr_q[o]   <= '0;
            end
        end else begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                state_q[o] <= state_d[o];
                owner_q[o] <= owner_d[o];
                ptr_q[o]   <= ptr_d[o];
            end
        end
    end

endmodule

// File: tb/tb_wormhole_switch_allocator.sv
// Directed bench for the wormhole switch allocator; expected outputs are queued per
// cycle and compared against the DUT a few time units after the falling edge.
module tb_wormhole_switch_allocator;
    import wormhole_switch_allocator_pkg::*;

    localparam logic [14:0] XS_IDLE = 15'h7FFF;

    logic clk = 1'b0;
    logic reset;

    wormhole_switch_allocator_if bus ();

    wormhole_switch_allocator dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [4:0]  grant;
        logic [4:0]  oval;
        logic [14:0] xsel;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Packs one 3-bit field per port, port 0 in the low bits.
    function automatic logic [14:0] pk(input int p0, input int p1, input int p2,
                                       input int p3, input int p4);
        return {3'(p4), 3'(p3), 3'(p2), 3'(p1), 3'(p0)};
    endfunction

    task automatic drive(input logic [4:0] v, input logic [4:0] h, input logic [4:0] t,
                         input logic [14:0] d, input logic [4:0] r);
        bus.in_valid  = v;
        bus.in_head   = h;
        bus.in_tail   = t;
        bus.in_dest   = d;
        bus.out_ready = r;
    endtask

    task automatic expect_out(input string tag, input logic [4:0] g, input logic [4:0] ov,
                              input logic [14:0] xs);
        exp_t e;
        e.tag   = tag;
        e.grant = g;
        e.oval  = ov;
        e.xsel  = xs;
        sb.push_back(e);
    endtask

    task automatic sample();
        exp_t e;
        e = sb.pop_front();
        vectors++;
        assert (bus.in_grant === e.grant) else begin
            miscompares++;
            $error("FAIL %s in_grant got %b want %b", e.tag, bus.in_grant, e.grant);
        end
        vectors++;
        assert (bus.out_valid === e.oval) else begin
            miscompares++;
            $error("FAIL %s out_valid got %b want %b", e.tag, bus.out_valid, e.oval);
        end
        vectors++;
        assert (bus.xbar_sel === e.xsel) else begin
            miscompares++;
            $error("FAIL %s xbar_sel got %h want %h", e.tag, bus.xbar_sel, e.xsel);
        end
    endtask

    task automatic step(input string tag, input logic [4:0] v, input logic [4:0] h,
                        input logic [4:0] t, input logic [14:0] d, input logic [4:0] r,
                        input logic [4:0] g, input logic [4:0] ov, input logic [14:0] xs);
        @(negedge clk);
        drive(v, h, t, d, r);
        expect_out(tag, g, ov, xs);
        #2;
        sample();
    endtask

    initial begin
        reset = 1'b1;
        drive(5'b0, 5'b0, 5'b0, 15'h0, 5'b11111);
        #3 reset = 1'b0;
        #1;
        expect_out("reset_async", 5'b0, 5'b0, XS_IDLE);
        sample();
        @(negedge clk);
        reset = 1'b1;
        step("idle", 5'b0, 5'b0, 5'b0, 15'h0, 5'b11111, 5'b0, 5'b0, XS_IDLE);

        // Round robin: inputs 2,3,4 stream single-flit packets to output 1.
        step("rr_arb2", 5'b11100, 5'b11100, 5'b11100, pk(0,0,1,1,1), 5'b11111,
             5'b00000, 5'b00000, XS_IDLE);
        step("rr_xfer2", 5'b11100, 5'b11100, 5'b11100, pk(0,0,1,1,1), 5'b11111,
             5'b00100, 5'b00010, pk(7,2,7,7,7));
        step("rr_arb3", 5'b11100, 5'b11100, 5'b11100, pk(0,0,1,1,1), 5'b11111,
             5'b00000, 5'b00000, XS_IDLE);
        step("rr_xfer3", 5'b11100, 5'b11100, 5'b11100, pk(0,0,1,1,1), 5'b11111,
             5'b01000, 5'b00010, pk(7,3,7,7,7));
        step("rr_arb4", 5'b11100, 5'b11100, 5'b11100, pk(0,0,1,1,1), 5'b11111,
             5'b00000, 5'b00000, XS_IDLE);
        step("rr_xfer4", 5'b11100, 5'b11100, 5'b11100, pk(0,0,1,1,1), 5'b11111,
             5'b10000, 5'b00010, pk(7,4,7,7,7));
        step("rr_arb2b", 5'b11100, 5'b11100, 5'b11100, pk(0,0,1,1,1), 5'b11111,
             5'b00000, 5'b00000, XS_IDLE);
        step("rr_xfer2b", 5'b11100, 5'b11100, 5'b11100, pk(0,0,1,1,1), 5'b11111,
             5'b00100, 5'b00010, pk(7,2,7,7,7));
        step("rr_end", 5'b0, 5'b0, 5'b0, 15'h0, 5'b11111, 5'b0, 5'b0, XS_IDLE);

        // Wormhole lock: 4-flit packet from input 0 to output 3, input 1 waits.
        step("lk_arb", 5'b00011, 5'b00011, 5'b00010, pk(3,3,0,0,0), 5'b11111,
             5'b00000, 5'b00000, XS_IDLE);
        step("lk_head", 5'b00011, 5'b00011, 5'b00010, pk(3,3,0,0,0), 5'b11111,
             5'b00001, 5'b01000, pk(7,7,7,0,7));
        step("lk_body1", 5'b00011, 5'b00010, 5'b00010, pk(3,3,0,0,0), 5'b11111,
             5'b00001, 5'b01000, pk(7,7,7,0,7));
        step("lk_body2", 5'b00011, 5'b00010, 5'b00010, pk(3,3,0,0,0), 5'b11111,
             5'b00001, 5'b01000, pk(7,7,7,0,7));
        step("lk_tail", 5'b00011, 5'b00010, 5'b00011, pk(3,3,0,0,0), 5'b11111,
             5'b00001, 5'b01000, pk(7,7,7,0,7));
        step("lk_arb1", 5'b00010, 5'b00010, 5'b00010, pk(3,3,0,0,0), 5'b11111,
             5'b00000, 5'b00000, XS_IDLE);
        step("lk_xfer1", 5'b00010, 5'b00010, 5'b00010, pk(3,3,0,0,0), 5'b11111,
             5'b00010, 5'b01000, pk(7,7,7,1,7));
        step("lk_end", 5'b0, 5'b0, 5'b0, 15'h0, 5'b11111, 5'b0, 5'b0, XS_IDLE);

        // Backpressure on output 3 for three cycles mid-packet.
        step("bp_arb", 5'b00011, 5'b00011, 5'b00010, pk(3,3,0,0,0), 5'b11111,
             5'b00000, 5'b00000, XS_IDLE);
        step("bp_head", 5'b00011, 5'b00011, 5'b00010, pk(3,3,0,0,0), 5'b11111,
             5'b00001, 5'b01000, pk(7,7,7,0,7));
        step("bp_body1", 5'b00011, 5'b00010, 5'b00010, pk(3,3,0,0,0), 5'b11111,
             5'b00001, 5'b01000, pk(7,7,7,0,7));
        for (int s = 0; s < 3; s++) begin
            step("bp_stall", 5'b00011, 5'b00010, 5'b00010, pk(3,3,0,0,0), 5'b10111,
                 5'b00000, 5'b00000, pk(7,7,7,0,7));
        end
        step("bp_body2", 5'b00011, 5'b00010, 5'b00010, pk(3,3,0,0,0), 5'b11111,
             5'b00001, 5'b01000, pk(7,7,7,0,7));
        step("bp_tail", 5'b00011, 5'b00010, 5'b00011, pk(3,3,0,0,0), 5'b11111,
             5'b00001, 5'b01000, pk(7,7,7,0,7));
        step("bp_arb1", 5'b00010, 5'b00010, 5'b00010, pk(3,3,0,0,0), 5'b11111,
             5'b00000, 5'b00000, XS_IDLE);
        step("bp_xfer1", 5'b00010, 5'b00010, 5'b00010, pk(3,3,0,0,0), 5'b11111,
             5'b00010, 5'b01000, pk(7,7,7,1,7));
        step("bp_end", 5'b0, 5'b0, 5'b0, 15'h0, 5'b11111, 5'b0, 5'b0, XS_IDLE);

        // Parallel outputs: 0->2, 1->4, 3->0 lock on the same edge.
        step("par_arb", 5'b01011, 5'b01011, 5'b01011, pk(2,4,0,0,0), 5'b11111,
             5'b00000, 5'b00000, XS_IDLE);
        step("par_xfer", 5'b01011, 5'b01011, 5'b01011, pk(2,4,0,0,0), 5'b11111,
             5'b01011, 5'b10101, pk(3,7,0,7,1));
        step("par_end", 5'b0, 5'b0, 5'b0, 15'h0, 5'b11111, 5'b0, 5'b0, XS_IDLE);

        // Reset during a locked 3-flit packet from input 2 to output 0.
        step("mr_arb", 5'b00100, 5'b00100, 5'b00000, 15'h0, 5'b11111,
             5'b00000, 5'b00000, XS_IDLE);
        step("mr_head", 5'b00100, 5'b00100, 5'b00000, 15'h0, 5'b11111,
             5'b00100, 5'b00001, pk(2,7,7,7,7));
        step("mr_body", 5'b00100, 5'b00000, 5'b00000, 15'h0, 5'b11111,
             5'b00100, 5'b00001, pk(2,7,7,7,7));
        #1 reset = 1'b0;
        #1;
        expect_out("mr_reset", 5'b0, 5'b0, XS_IDLE);
        sample();
        drive(5'b0, 5'b0, 5'b0, 15'h0, 5'b11111);
        @(negedge clk);
        reset = 1'b1;

        // Pointer back at 0 picks input 1 over 4; dest 6 and orphan body never win.
        step("rs_arb1", 5'b11110, 5'b11010, 5'b11010, pk(0,0,0,6,0), 5'b11111,
             5'b00000, 5'b00000, XS_IDLE);
        step("rs_xfer1", 5'b11110, 5'b11010, 5'b11010, pk(0,0,0,6,0), 5'b11111,
             5'b00010, 5'b00001, pk(1,7,7,7,7));
        step("rs_arb4", 5'b11100, 5'b11000, 5'b11000, pk(0,0,0,6,0), 5'b11111,
             5'b00000, 5'b00000, XS_IDLE);
        step("rs_xfer4", 5'b11100, 5'b11000, 5'b11000, pk(0,0,0,6,0), 5'b11111,
             5'b10000, 5'b00001, pk(4,7,7,7,7));
        step("rs_bad1", 5'b01100, 5'b01000, 5'b01000, pk(0,0,0,6,0), 5'b11111,
             5'b00000, 5'b00000, XS_IDLE);
        step("rs_bad2", 5'b01100, 5'b01000, 5'b01000, pk(0,0,0,6,0), 5'b11111,
             5'b00000, 5'b00000, XS_IDLE);
        step("rs_end", 5'b0, 5'b0, 5'b0, 15'h0, 5'b11111, 5'b0, 5'b0, XS_IDLE);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
